// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART byte-stream command parser driving a single-cycle register bus
// Optional checksum byte and compare enabled by defining UART_CMD_CHECKSUM_EN.
module uart_cmd_ctrl #(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int RD_WAIT        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [7:0]        reg_rdata,
    input  logic              reg_rvalid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              frame_err
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RD_W  = $clog2(RD_WAIT + 1);

    localparam logic [7:0] SYNC  = 8'hA5;
    localparam logic [7:0] OP_WR = 8'h57;
    localparam logic [7:0] OP_RD = 8'h52;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE, S_OP, S_ADDR, S_DATA, S_CHK, S_EXEC, S_RDWAIT, S_RESP
    } state_t;

    state_t            state, state_next;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [RD_W-1:0]   rd_cnt;
    logic              is_write;
    logic [7:0]        addr_byte;
    logic              tmo_hit, timed;
    logic              set_op, latch_addr, latch_data, load_resp;
    logic [7:0]        resp_byte;

    assign reg_addr = addr_byte[ADDR_W-1:0];
    assign tmo_hit  = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign timed    = (state == S_OP) || (state == S_ADDR) ||
                      (state == S_DATA) || (state == S_CHK);

`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0] chk_expect;
    assign chk_expect = (is_write ? OP_WR : OP_RD) ^ addr_byte ^ (is_write ? reg_wdata : 8'h00);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        frame_err  = 1'b0;
        reg_wr     = 1'b0;
        reg_rd     = 1'b0;
        set_op     = 1'b0;
        latch_addr = 1'b0;
        latch_data = 1'b0;
        load_resp  = 1'b0;
        resp_byte  = 8'h00;
        tx_valid   = (state == S_RESP);
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (rx_valid && rx_data == SYNC) state_next = S_OP;
            end
            S_OP: begin
                if (rx_valid) begin
                    if (rx_data == OP_WR || rx_data == OP_RD) begin
                        set_op     = 1'b1;
                        state_next = S_ADDR;
                    end else begin
                        frame_err  = 1'b1;
                        load_resp  = 1'b1;
                        resp_byte  = NAK;
                        state_next = S_RESP;
                    end
                end else if (tmo_hit) begin
                    frame_err  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_ADDR: begin
                if (rx_valid) begin
                    latch_addr = 1'b1;
`ifdef UART_CMD_CHECKSUM_EN
                    state_next = is_write ? S_DATA : S_CHK;
`else
                    state_next = is_write ? S_DATA : S_EXEC;
`endif
                end else if (tmo_hit) begin
                    frame_err  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    latch_data = 1'b1;
`ifdef UART_CMD_CHECKSUM_EN
                    state_next = S_CHK;
`else
                    state_next = S_EXEC;
`endif
                end else if (tmo_hit) begin
                    frame_err  = 1'b1;
                    state_next = S_IDLE;
                end
            end
`ifdef UART_CMD_CHECKSUM_EN
            S_CHK: begin
                if (rx_valid) begin
                    if (rx_data == chk_expect) begin
                        state_next = S_EXEC;
                    end else begin
                        frame_err  = 1'b1;
                        load_resp  = 1'b1;
                        resp_byte  = NAK;
                        state_next = S_RESP;
                    end
                end else if (tmo_hit) begin
                    frame_err  = 1'b1;
                    state_next = S_IDLE;
                end
            end
`endif
            S_EXEC: begin
                if (is_write) begin
                    reg_wr     = 1'b1;
                    load_resp  = 1'b1;
                    resp_byte  = ACK;
                    state_next = S_RESP;
                end else begin
                    reg_rd     = 1'b1;
                    state_next = S_RDWAIT;
                end
            end
            S_RDWAIT: begin
                // Data arriving on the last wait cycle still counts.
                if (reg_rvalid) begin
                    load_resp  = 1'b1;
                    resp_byte  = reg_rdata;
                    state_next = S_RESP;
                end else if (rd_cnt == RD_W'(RD_WAIT - 1)) begin
                    frame_err  = 1'b1;
                    load_resp  = 1'b1;
                    resp_byte  = NAK;
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (tx_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt   <= '0;
            rd_cnt    <= '0;
            is_write  <= 1'b0;
            addr_byte <= 8'h00;
            reg_wdata <= 8'h00;
            tx_data   <= 8'h00;
        end else begin
            // Every accepted byte in a timed state changes state, so this also clears per byte.
            if (state_next != state || !timed) tmo_cnt <= '0;
            else                               tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (state == S_RDWAIT && state_next == S_RDWAIT) rd_cnt <= rd_cnt + RD_W'(1);
            else                                             rd_cnt <= '0;
            if (set_op)     is_write  <= (rx_data == OP_WR);
            if (latch_addr) addr_byte <= rx_data;
            if (latch_data) reg_wdata <= rx_data;
            if (load_resp)  tx_data   <= resp_byte;
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - directed self-checking bench for uart_cmd_ctrl
module tb_uart_cmd_ctrl;

    localparam int ADDR_W  = 8;
    localparam int TMO     = 20;
    localparam int RD_WAIT = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_wr;
    logic              reg_rd;
    logic [7:0]        reg_rdata;
    logic              reg_rvalid;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              frame_err;

    int n_chk = 0;
    int n_pass = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int err_cnt = 0;

    uart_cmd_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO), .RD_WAIT(RD_WAIT)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
        .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n) begin
            if (reg_wr)    wr_cnt++;
            if (reg_rd)    rd_cnt++;
            if (frame_err) err_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        #1;
    endtask

    task automatic accept_resp();
        @(negedge clk);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        #1;
    endtask

    initial begin
        logic bad;
        rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        reg_rdata = 8'h00; reg_rvalid = 1'b0; tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_strobes", {reg_wr, reg_rd, tx_valid, busy, frame_err}, 5'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_addr", {reg_addr, reg_wdata}, 16'h0000);
        rst_n = 1'b1;

        // Non-sync byte in IDLE is ignored
        send_byte(8'h57);
        chk("idle_ignore", busy, 1'b0);

        // Write frame
        send_byte(8'hA5); send_byte(8'h57); send_byte(8'h10); send_byte(8'h3C);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(8'h7B);
`endif
        chk("wr_strobe", {reg_wr, reg_rd}, 2'b10);
        chk("wr_addr", reg_addr, 8'h10);
        chk("wr_wdata", reg_wdata, 8'h3C);
        chk("wr_txv_early", tx_valid, 1'b0);
        @(negedge clk); #1;
        chk("wr_txv", tx_valid, 1'b1);
        chk("wr_ack", tx_data, 8'h06);
        accept_resp();
        chk("wr_done", {busy, tx_valid}, 2'b00);
        chk("wr_count", wr_cnt, 1);

        // Read, rvalid alongside reg_rd ignored, real data 3 cycles later
        send_byte(8'hA5); send_byte(8'h52); send_byte(8'h22);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(8'h70);
`endif
        chk("rd_strobe", {reg_wr, reg_rd}, 2'b01);
        chk("rd_addr", reg_addr, 8'h22);
        reg_rvalid = 1'b1; reg_rdata = 8'h11;
        @(negedge clk); reg_rvalid = 1'b0;
        @(negedge clk);
        @(negedge clk); reg_rvalid = 1'b1; reg_rdata = 8'h9E; #1;
        chk("rd_txv_early", tx_valid, 1'b0);
        @(negedge clk); reg_rvalid = 1'b0; #1;
        chk("rd_txv", tx_valid, 1'b1);
        chk("rd_data", tx_data, 8'h9E);
        accept_resp();
        chk("rd_count", rd_cnt, 1);

        // Read with no rvalid: NAK after RD_WAIT cycles
        send_byte(8'hA5); send_byte(8'h52); send_byte(8'h22);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(8'h70);
`endif
        repeat (RD_WAIT - 1) @(negedge clk);
        #1;
        chk("rdto_early", frame_err, 1'b0);
        @(negedge clk); #1;
        chk("rdto_err", {frame_err, tx_valid}, 2'b10);
        @(negedge clk); #1;
        chk("rdto_nak", {tx_valid, tx_data}, 9'h115);
        accept_resp();
        chk("rdto_errcnt", err_cnt, 1);

        // Bad opcode; following bytes dropped while response pending
        send_byte(8'hA5); send_byte(8'h41);
        chk("badop_nak", {tx_valid, tx_data}, 9'h115);
        chk("badop_errcnt", err_cnt, 2);
        send_byte(8'hA5); send_byte(8'h57); send_byte(8'h10); send_byte(8'h3C);
        chk("badop_hold", {busy, tx_valid, tx_data}, 10'h315);
        accept_resp();
        chk("badop_idle", busy, 1'b0);
        chk("badop_nostrobe", {wr_cnt, rd_cnt}, {32'd1, 32'd2});

`ifdef UART_CMD_CHECKSUM_EN
        send_byte(8'hA5); send_byte(8'h57); send_byte(8'h10); send_byte(8'h3C);
        send_byte(8'h00);
        chk("chk_nak", {tx_valid, tx_data}, 9'h115);
        accept_resp();
        chk("chk_errcnt", err_cnt, 3);
        chk("chk_nowr", wr_cnt, 1);
        err_cnt = err_cnt - 1;
`endif

        // Inter-byte timeout in ADDR
        send_byte(8'hA5); send_byte(8'h57);
        repeat (TMO - 2) @(negedge clk);
        #1;
        chk("tmo_early", {frame_err, busy}, 2'b01);
        @(negedge clk); #1;
        chk("tmo_err", {frame_err, busy}, 2'b11);
        @(negedge clk); #1;
        chk("tmo_idle", {busy, tx_valid}, 2'b00);
        chk("tmo_errcnt", err_cnt, 3);

        // Frame after timeout, then backpressure
        send_byte(8'hA5); send_byte(8'h57); send_byte(8'h05); send_byte(8'hAA);
`ifdef UART_CMD_CHECKSUM_EN
        send_byte(8'h57 ^ 8'h05 ^ 8'hAA);
`endif
        chk("post_tmo_wr", {reg_wr, reg_addr, reg_wdata}, 17'h105AA);
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (tx_valid !== 1'b1 || tx_data !== 8'h06) bad = 1'b1;
        end
        chk("bp_stable", bad, 1'b0);
        accept_resp();
        chk("bp_done", {busy, tx_valid}, 2'b00);

        // Reset mid-frame
        send_byte(8'hA5); send_byte(8'h57); send_byte(8'h10);
        @(negedge clk);
        rx_data = 8'h3C; rx_valid = 1'b1; rst_n = 1'b0;
        @(negedge clk); #1;
        chk("midrst_out", {reg_wr, reg_rd, tx_valid, busy, frame_err}, 5'b0);
        chk("midrst_regs", {tx_data, reg_addr, reg_wdata}, 24'h0);
        rx_valid = 1'b0; rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("midrst_quiet", {busy, tx_valid}, 2'b00);
        chk("midrst_wrcnt", wr_cnt, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Command sequencer between the UART receiver and the register bus of the UART register access system. It consumes the byte stream produced by the receiver (`data_out`/`data_ready`), parses it into read/write command frames and issues single-cycle register bus accesses. It then queues a one-byte response (read data, ACK or NAK) toward the UART transmitter over a valid/ready handshake.

## Interface
- `ADDR_W`, 8: register address width, 1..8; the address byte's low `ADDR_W` bits are used.
- `TIMEOUT_CYCLES`, 1000000: maximum idle clocks between bytes inside a frame.
- `RD_WAIT`, 16: maximum clocks from `reg_rd` to `reg_rvalid`.
- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `rx_data`  in  8  received byte; connects to the receiver's `data_out`.
- `rx_valid`  in  1  one-cycle pulse per byte; connects to the receiver's `data_ready`.
- `reg_addr`  out  ADDR_W  register address, stable from the EXEC cycle until the return to IDLE.
- `reg_wdata`  out  8  write data.
- `reg_wr`  out  1  one-cycle write strobe.
- `reg_rd`  out  1  one-cycle read strobe.
- `reg_rdata`  in  8  read data, sampled when `reg_rvalid` is high.
- `reg_rvalid`  in  1  read data valid.
- `tx_data`  out  8  response byte.
- `tx_valid`  out  1  response valid; held until accepted.
- `tx_ready`  in  1  transmitter can accept a byte.
- `busy`  out  1  high whenever the state is not IDLE.
- `frame_err`  out  1  one-cycle pulse on any frame or access error.

## Operation
- Frame format: SYNC `0xA5`, then OP, then ADDR, then DATA (writes only), then CHK (only with `UART_CMD_CHECKSUM_EN`).
- OP values: `0x57` is write, `0x52` is read.
- Responses:
  - Read returns the read data byte.
  - Write returns ACK `0x06`.
  - Any error returns NAK `0x15`, except a timeout, which sends no response.
- States and transitions:
  - IDLE: on `rx_valid` with `0xA5`, go to OP. Any other byte is ignored.
  - OP: a valid opcode goes to ADDR. Any other value asserts `frame_err`, loads NAK and goes to RESP.
  - ADDR: latch the address. A write goes to DATA. A read goes to CHK if the checksum is enabled, otherwise to EXEC.
  - DATA: latch the data, then go to CHK or EXEC.
  - CHK: the received byte must equal the XOR of OP, ADDR and DATA (DATA only for writes). On a match go to EXEC. On a mismatch assert `frame_err`, load NAK and go to RESP; no bus access occurs.
  - EXEC, write: pulse `reg_wr`, load ACK, go to RESP.
  - EXEC, read: pulse `reg_rd`, go to RDWAIT.
  - RDWAIT: `reg_rvalid` loads `reg_rdata` as the response and goes to RESP. If `RD_WAIT` cycles pass without `reg_rvalid`, assert `frame_err`, load NAK and go to RESP.
  - RESP: drive `tx_valid`. On `tx_valid && tx_ready`, go to IDLE.
- Inter-byte timeout:
  - Applies in OP, ADDR, DATA and CHK.
  - The counter clears on entry to each of these states and on every accepted byte.
  - When it reaches `TIMEOUT_CYCLES-1`: go to IDLE, pulse `frame_err`, send no response.
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- `rx_valid` in EXEC, RDWAIT or RESP: the byte is dropped and does not start a new frame.
- A second `0xA5` received in OP is treated as a bad opcode (NAK); there is no resync.

## Timing
- Reset values: all outputs 0, state IDLE, timeout and read-wait counters 0.
- Reset mid-frame aborts the frame immediately; no strobes or response follow.
- Stage advance: the state advances on the clock edge that samples `rx_valid`.
- Strobe timing: EXEC lasts exactly one cycle. `reg_wr` or `reg_rd` is high in the cycle after the final frame byte is accepted.
- Read data:
  - `reg_rvalid` is honoured from the cycle after `reg_rd`.
  - `reg_rvalid` in the same cycle as `reg_rd` is ignored.
  - `reg_rvalid` on the final wait cycle wins over the timeout.
- Response latency: `tx_valid` rises in the cycle after the response byte is loaded.
- Handshake: `tx_data` is stable while `tx_valid` is high. The transfer occurs in the cycle where `tx_valid && tx_ready`. `tx_valid` drops and `busy` drops in the next cycle.
- `frame_err` is high for exactly one cycle, coincident with the error transition.

## Configuration
- `UART_CMD_CHECKSUM_EN` defined: the CHK state and checksum byte are present, and a mismatch produces NAK.
- Undefined: no CHK state, and frames end at ADDR (read) or DATA (write). The checksum compare logic is not synthesised.

## Test plan
- Write: bytes A5 57 10 3C (plus CHK 0x7B if enabled) -> one `reg_wr` pulse with `reg_addr`=0x10 and `reg_wdata`=0x3C, then `tx_data`=0x06.
- Read: A5 52 22 (plus CHK 0x70), with `reg_rvalid` 3 cycles after `reg_rd` carrying 0x9E -> `tx_data`=0x9E. With `reg_rvalid` never asserted -> after 16 cycles, `frame_err` pulses and `tx_data`=0x15.
- Bad opcode: A5 41 -> `frame_err` pulse and NAK 0x15, no strobes. Following bytes are dropped until `tx_ready`.
- Checksum (enabled): A5 57 10 3C 00 -> NAK 0x15, `frame_err` pulse, no `reg_wr`.
- Timeout: A5 57, then silence for `TIMEOUT_CYCLES` -> `frame_err` pulse, `busy` low, no `tx_valid`. A following complete write frame executes normally.
- Backpressure and reset: hold `tx_ready`=0 for 50 cycles -> `tx_valid`/`tx_data` stable throughout. Asserting `rst_n`=0 mid-frame -> all outputs 0 on the next edge.
